memory_island_bank_arb: RTL

//  Per-bank arbiter for the memory island: grants one of NumNarrow narrow and NumWide wide

---
 rtl/memory_island_pkg.sv | 31 +++
 rtl/memory_island_rr_pick.sv | 46 ++++
 rtl/memory_island_bank_arb.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/memory_island_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_island_pkg
//  Description : Shared types and helpers for the memory island bank arbiter.
//                Holds the response tag carried through the bank latency
//                pipeline and index-width helpers for the round-robin pickers.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_island_pkg;

  // Widest requester index the response tag can carry (up to 256 per class).
  localparam int unsigned MaxIdxWidth = 8;

  // One pipeline slot: which port (class + index) owns the returning beat.
  typedef struct packed {
    logic                   valid;
    logic                   is_wide;
    logic [MaxIdxWidth-1:0] idx;
  } resp_tag_t;

  // Index width for a class of n requesters; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_island_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : memory_island_rr_pick
//  Description : Round-robin picker. Returns the first requester at or after
//                the pointer (wrapping), as a onehot vector and an index.
//                The pointer register lives in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_island_rr_pick
  import memory_island_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Two passes: first requesters at/after the pointer, then those before it.
  always_comb begin
    int unsigned ptr_u;
    ptr_u    = 32'(ptr_i);
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!valid_o && req_i[j] && (j >= ptr_u)) begin
        valid_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IdxW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!valid_o && req_i[j] && (j < ptr_u)) begin
        valid_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IdxW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_island_bank_arb.sv
`default_nettype none
// ============================================================================
//  Module      : memory_island_bank_arb
//  Description : Per-bank arbiter. Grants one narrow or wide requester per
//                cycle onto a single always-ready SRAM bank, wide class first
//                with a starvation escape for narrow, and routes each response
//                back to its port a fixed BankLatency cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_island_bank_arb
  import memory_island_pkg::*;
#(
  parameter  int unsigned NumNarrow        = 4,
  parameter  int unsigned NumWide          = 2,
  parameter  int unsigned BankAddrWidth    = 10,
  parameter  int unsigned DataWidth        = 32,
  parameter  int unsigned BankLatency      = 1,
  parameter  int unsigned WidePriorityWait = 0,
  localparam int unsigned StrbWidth        = DataWidth / 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  // narrow requesters
  input  logic [NumNarrow-1:0]               narrow_req_i,
  output logic [NumNarrow-1:0]               narrow_gnt_o,
  input  logic [NumNarrow*BankAddrWidth-1:0] narrow_addr_i,
  input  logic [NumNarrow-1:0]               narrow_we_i,
  input  logic [NumNarrow*DataWidth-1:0]     narrow_wdata_i,
  input  logic [NumNarrow*StrbWidth-1:0]     narrow_strb_i,
  output logic [NumNarrow-1:0]               narrow_rvalid_o,
  output logic [NumNarrow*DataWidth-1:0]     narrow_rdata_o,
  // wide requesters
  input  logic [NumWide-1:0]                 wide_req_i,
  output logic [NumWide-1:0]                 wide_gnt_o,
  input  logic [NumWide*BankAddrWidth-1:0]   wide_addr_i,
  input  logic [NumWide-1:0]                 wide_we_i,
  input  logic [NumWide*DataWidth-1:0]       wide_wdata_i,
  input  logic [NumWide*StrbWidth-1:0]       wide_strb_i,
  output logic [NumWide-1:0]                 wide_rvalid_o,
  output logic [NumWide*DataWidth-1:0]       wide_rdata_o,
  // SRAM bank
  output logic                               bank_req_o,
  output logic                               bank_we_o,
  output logic [BankAddrWidth-1:0]           bank_addr_o,
  output logic [DataWidth-1:0]               bank_wdata_o,
  output logic [StrbWidth-1:0]               bank_be_o,
  input  logic [DataWidth-1:0]               bank_rdata_i
);

  localparam int unsigned NIdxW   = idx_width(NumNarrow);
  localparam int unsigned WIdxW   = idx_width(NumWide);
  localparam int unsigned StarveW = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(WidePriorityWait);

  logic [NIdxW-1:0]   narrow_ptr_q, narrow_ptr_d;
  logic [WIdxW-1:0]   wide_ptr_q, wide_ptr_d;
  logic [StarveW-1:0] starve_q, starve_d;
  resp_tag_t          tag_q [BankLatency];
  resp_tag_t          tag_d [BankLatency];

  logic [NumNarrow-1:0] narrow_onehot;
  logic [NIdxW-1:0]     narrow_idx;
  logic                 narrow_any;
  logic [NumWide-1:0]   wide_onehot;
  logic [WIdxW-1:0]     wide_idx;
  logic                 wide_any;

  logic      sel_wide;
  logic      sel_narrow;
  logic      starved;
  resp_tag_t resp_tag;

  memory_island_rr_pick #(.N(NumNarrow)) u_narrow_pick (
    .req_i    (narrow_req_i),
    .ptr_i    (narrow_ptr_q),
    .onehot_o (narrow_onehot),
    .idx_o    (narrow_idx),
    .valid_o  (narrow_any)
  );

  memory_island_rr_pick #(.N(NumWide)) u_wide_pick (
    .req_i    (wide_req_i),
    .ptr_i    (wide_ptr_q),
    .onehot_o (wide_onehot),
    .idx_o    (wide_idx),
    .valid_o  (wide_any)
  );

  // Class select: wide first unless narrow has waited the full budget; no grants in reset.
  always_comb begin
    sel_wide   = 1'b0;
    sel_narrow = 1'b0;
    starved    = (WidePriorityWait != 0) && (starve_q == StarveMax) && narrow_any;
    if (rst_ni) begin
      sel_wide   = wide_any && !starved;
      sel_narrow = narrow_any && !sel_wide;
    end
    narrow_gnt_o = sel_narrow ? narrow_onehot : '0;
    wide_gnt_o   = sel_wide ? wide_onehot : '0;
  end

  // Next-state for round-robin pointers, starvation counter and response pipeline.
  always_comb begin
    resp_tag_t new_tag;
    narrow_ptr_d = narrow_ptr_q;
    wide_ptr_d   = wide_ptr_q;
    starve_d     = starve_q;
    new_tag      = '0;

    if (sel_narrow) begin
      narrow_ptr_d = (narrow_idx == NIdxW'(NumNarrow - 1)) ? '0 : narrow_idx + 1'b1;
    end
    if (sel_wide) begin
      wide_ptr_d = (wide_idx == WIdxW'(NumWide - 1)) ? '0 : wide_idx + 1'b1;
    end

    // Counts cycles a pending narrow request loses to wide; any narrow win resets it.
    if ((WidePriorityWait == 0) || !narrow_any || sel_narrow) begin
      starve_d = '0;
    end else if (sel_wide && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end

    new_tag.valid   = sel_narrow | sel_wide;
    new_tag.is_wide = sel_wide;
    new_tag.idx     = sel_wide ? MaxIdxWidth'(wide_idx) : MaxIdxWidth'(narrow_idx);

    tag_d[0] = new_tag;
    for (int unsigned i = 1; i < BankLatency; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // State registers; reset drops every response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      narrow_ptr_q <= '0;
      wide_ptr_q   <= '0;
      starve_q     <= '0;
      for (int unsigned i = 0; i < BankLatency; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      narrow_ptr_q <= narrow_ptr_d;
      wide_ptr_q   <= wide_ptr_d;
      starve_q     <= starve_d;
      for (int unsigned i = 0; i < BankLatency; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Drive the bank from whichever single port holds the grant; all-zero when idle.
  always_comb begin
    bank_req_o   = sel_narrow | sel_wide;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    for (int unsigned i = 0; i < NumNarrow; i++) begin
      if (narrow_gnt_o[i]) begin
        bank_we_o    = narrow_we_i[i];
        bank_addr_o  = narrow_addr_i[i*BankAddrWidth +: BankAddrWidth];
        bank_wdata_o = narrow_wdata_i[i*DataWidth +: DataWidth];
        bank_be_o    = narrow_strb_i[i*StrbWidth +: StrbWidth];
      end
    end
    for (int unsigned i = 0; i < NumWide; i++) begin
      if (wide_gnt_o[i]) begin
        bank_we_o    = wide_we_i[i];
        bank_addr_o  = wide_addr_i[i*BankAddrWidth +: BankAddrWidth];
        bank_wdata_o = wide_wdata_i[i*DataWidth +: DataWidth];
        bank_be_o    = wide_strb_i[i*StrbWidth +: StrbWidth];
      end
    end
  end

  assign resp_tag = tag_q[BankLatency-1];

  for (genvar gi = 0; gi < NumNarrow; gi++) begin : g_narrow_resp
    assign narrow_rvalid_o[gi] = resp_tag.valid && !resp_tag.is_wide &&
                                 (resp_tag.idx == MaxIdxWidth'(gi));
    assign narrow_rdata_o[gi*DataWidth +: DataWidth] = bank_rdata_i;
  end

  for (genvar gi = 0; gi < NumWide; gi++) begin : g_wide_resp
    assign wide_rvalid_o[gi] = resp_tag.valid && resp_tag.is_wide &&
                               (resp_tag.idx == MaxIdxWidth'(gi));
    assign wide_rdata_o[gi*DataWidth +: DataWidth] = bank_rdata_i;
  end

endmodule
`default_nettype wire
